des_key_schedule: RTL and testbench

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

---
 rtl/des_pkg.sv | 36 +++
 rtl/pc1.sv | 23 ++
 rtl/des_key_schedule.sv | 100 ++++++++++
 tb/tb_des_key_schedule.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared constants, FSM encoding and 28-bit half rotation helpers for the DES key schedule.
package des_pkg;

   localparam int ROUNDS = 16;
   localparam int HALF   = 28;

   localparam logic [15:0] SHIFT_ONE_MASK_DEFAULT = 16'h8103;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Circular rotation of one 28-bit half by 1 or 2 positions.
   function automatic logic [HALF-1:0] rot_half(input logic [HALF-1:0] v,
                                                input logic right,
                                                input logic one);
      logic [HALF-1:0] r;
      case ({right, one})
         2'b01:   r = {v[HALF-2:0], v[HALF-1]};
         2'b00:   r = {v[HALF-3:0], v[HALF-1:HALF-2]};
         2'b11:   r = {v[0], v[HALF-1:1]};
         default: r = {v[1:0], v[HALF-1:2]};
      endcase
      return r;
   endfunction

   // C and D rotate independently; neither ever spills into the other.
   function automatic logic [2*HALF-1:0] rot_cd(input logic [2*HALF-1:0] cd,
                                                input logic right,
                                                input logic one);
      return {rot_half(cd[2*HALF-1:HALF], right, one),
              rot_half(cd[HALF-1:0], right, one)};
   endfunction

endpackage

// File: rtl/pc1.sv
// DES permuted choice 1: 64-bit key (MSB = DES bit 1) to 56-bit {C0,D0}, parity bits dropped.
module pc1 (
   input  logic [64:1] in,
   output logic [56:1] out
);

   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   // Table entries use DES numbering, so DES bit b lives at index 65-b of the vector.
   for (genvar gi = 0; gi < 56; gi++) begin : g_pc1
      assign out[56-gi] = in[65-PC1_TAB[gi]];
   end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: presents one {C,D} round state per handshake, in encrypt or decrypt order.
module des_key_schedule
   import des_pkg::*;
#(
   parameter logic [15:0] SHIFT_ONE_MASK = SHIFT_ONE_MASK_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [64:1] key_in,
   input  logic        decrypt,
   input  logic        start,
   input  logic        round_ready,
   output logic [56:1] state_out,
   output logic        round_valid,
   output logic [4:1]  round_idx,
   output logic        last_round,
   output logic        busy,
   output logic        done
);

   localparam logic [4:0] LAST_IDX = 5'(ROUNDS);

   state_t      state_reg, state_next;
   logic [56:1] cd_reg, cd_next;
   logic [4:0]  idx_reg, idx_next;
   logic        dec_reg, dec_next;
   logic        done_reg, done_next;
   logic [56:1] pc1_cd;
   logic [3:0]  dec_sel;
   logic        step_one;

   pc1 u_pc1 (
      .in  (key_in),
      .out (pc1_cd)
   );

   // Next encrypt step is round idx+1 (mask bit idx); decrypt step is round 17-idx (mask bit 16-idx).
   assign dec_sel  = 4'd0 - idx_reg[3:0];
   assign step_one = dec_reg ? SHIFT_ONE_MASK[dec_sel] : SHIFT_ONE_MASK[idx_reg[3:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         cd_reg    <= '0;
         idx_reg   <= '0;
         dec_reg   <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cd_reg    <= cd_next;
         idx_reg   <= idx_next;
         dec_reg   <= dec_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cd_next    = cd_reg;
      idx_next   = idx_reg;
      dec_next   = dec_reg;
      done_next  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_RUN;
               idx_next   = 5'd1;
               dec_next   = decrypt;
               // Decrypt starts from C16,D16, which is PC1 output unrotated.
               cd_next    = decrypt ? pc1_cd : rot_cd(pc1_cd, 1'b0, SHIFT_ONE_MASK[0]);
            end
         end
         ST_RUN: begin
            if (round_ready) begin
               if (idx_reg == LAST_IDX) begin
                  state_next = ST_IDLE;
                  done_next  = 1'b1;
                  // Decrypt owes one final right shift to land back on {C0,D0}.
                  if (dec_reg) begin
                     cd_next = rot_cd(cd_reg, 1'b1, step_one);
                  end
               end else begin
                  idx_next = idx_reg + 5'd1;
                  cd_next  = rot_cd(cd_reg, dec_reg, step_one);
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Round 16 appears as 4'h0 on the 4-bit round_idx port; last_round disambiguates it.
   assign state_out   = cd_reg;
   assign round_idx   = idx_reg[3:0];
   assign round_valid = (state_reg == ST_RUN);
   assign busy        = (state_reg != ST_IDLE);
   assign last_round  = round_valid && (idx_reg == LAST_IDX);
   assign done        = done_reg;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1 key walkthrough.
module tb_des_key_schedule;

   logic        clk = 1'b0;
   logic        rst;
   logic [64:1] key_in;
   logic        decrypt;
   logic        start;
   logic        round_ready;
   logic [56:1] state_out;
   logic        round_valid;
   logic [4:1]  round_idx;
   logic        last_round;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
   localparam logic [55:0] CD0 = 56'hF0CCAAF_556678F;
   localparam logic [47:0] K1  = 48'h1B02EFFC7072;

   localparam logic [55:0] ENC [16] = '{
      56'hE19955F_AACCF1E, 56'hC332ABF_5599E3D, 56'h0CCAAFF_56678F5, 56'h332ABFC_599E3D5,
      56'hCCAAFF0_6678F55, 56'h32ABFC3_99E3D55, 56'hCAAFF0C_678F556, 56'h2ABFC33_9E3D559,
      56'h557F866_3C7AAB3, 56'h55FE199_F1EAACC, 56'h57F8665_C7AAB33, 56'h5FE1995_1EAACCF,
      56'h7F86655_7AAB33C, 56'hFE19955_EAACCF1, 56'hF866557_AAB33C7, 56'hF0CCAAF_556678F
   };

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   always #5 clk = ~clk;

   des_key_schedule dut (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in),
      .decrypt     (decrypt),
      .start       (start),
      .round_ready (round_ready),
      .state_out   (state_out),
      .round_valid (round_valid),
      .round_idx   (round_idx),
      .last_round  (last_round),
      .busy        (busy),
      .done        (done)
   );

   function automatic logic [47:0] pc2(input logic [55:0] s);
      logic [47:0] k;
      for (int j = 0; j < 48; j++) k[47-j] = s[56-PC2_TAB[j]];
      return k;
   endfunction

   // Pulse start for one edge, then scramble key/mode to show they are don't-care afterwards.
   task automatic launch(input logic [63:0] key, input logic dec);
      key_in  = key;
      decrypt = dec;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      key_in  = 64'hA5A5_5A5A_0F0F_F0F0;
      decrypt = ~dec;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; round_ready = 1'b0; key_in = '0; decrypt = 1'b0;
      @(negedge clk);
      checks++;
      if (state_out !== 56'h0 || round_idx !== 4'h0) begin
         failures++;
         $display("FAIL reset_data got state=%h idx=%h exp state=0 idx=0", state_out, round_idx);
      end
      checks++;
      if ({round_valid, busy, done, last_round} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ctrl got v/b/d/l=%b exp 0000", {round_valid, busy, done, last_round});
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({round_valid, busy, done} !== 3'b000 || state_out !== 56'h0) begin
         failures++;
         $display("FAIL idle_after_reset got v/b/d=%b state=%h exp 000 state=0", {round_valid, busy, done}, state_out);
      end
      $display("test_reset: done");
   endtask

   task automatic run_full(input logic dec, input string name);
      logic [7:0]  got_ctrl, exp_ctrl;
      logic [55:0] exp_state;
      logic [3:0]  exp_idx;
      round_ready = 1'b1;
      launch(KEY, dec);
      for (int r = 1; r <= 16; r++) begin
         exp_state = dec ? ENC[16-r] : ENC[r-1];
         exp_idx   = 4'(r);
         checks++;
         if (state_out !== exp_state) begin
            failures++;
            $display("FAIL %s_state r=%0d got=%h exp=%h", name, r, state_out, exp_state);
         end
         got_ctrl = {round_valid, round_idx, last_round, busy, done};
         exp_ctrl = {1'b1, exp_idx, (r == 16), 1'b1, 1'b0};
         checks++;
         if (got_ctrl !== exp_ctrl) begin
            failures++;
            $display("FAIL %s_ctrl r=%0d got=%b exp=%b", name, r, got_ctrl, exp_ctrl);
         end
         if (r == 1 && !dec) begin
            checks++;
            if (pc2(state_out) !== K1) begin
               failures++;
               $display("FAIL enc_k1_pc2 got=%h exp=%h", pc2(state_out), K1);
            end
         end
         @(negedge clk);
      end
      // 17 edges after the start edge: done pulses and the state has returned to {C0,D0}.
      checks++;
      if ({done, round_valid, busy, last_round} !== 4'b1000 || state_out !== CD0) begin
         failures++;
         $display("FAIL %s_finish got d/v/b/l=%b state=%h exp 1000 state=%h", name, {done, round_valid, busy, last_round}, state_out, CD0);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || state_out !== CD0) begin
         failures++;
         $display("FAIL %s_done_pulse got done=%b state=%h exp done=0 state=%h", name, done, state_out, CD0);
      end
      $display("%s schedule: done", name);
   endtask

   task automatic test_encrypt;
      run_full(1'b0, "enc");
   endtask

   task automatic test_decrypt;
      run_full(1'b1, "dec");
   endtask

   task automatic test_stall;
      int         r;
      int         cyc;
      logic       rdy;
      logic [3:0] exp_idx;
      round_ready = 1'b0;
      launch(KEY, 1'b0);
      r = 1;
      cyc = 0;
      while (r <= 16 && cyc < 400) begin
         exp_idx = 4'(r);
         checks++;
         if (round_valid !== 1'b1 || done !== 1'b0 || round_idx !== exp_idx || state_out !== ENC[r-1]) begin
            failures++;
            $display("FAIL stall_hold r=%0d cyc=%0d got v=%b d=%b idx=%h state=%h exp v=1 d=0 idx=%h state=%h",
                     r, cyc, round_valid, done, round_idx, state_out, exp_idx, ENC[r-1]);
         end
         // Force a long stall on round 7, random stalls elsewhere.
         if (r == 7 && cyc < 60) rdy = (cyc % 8 == 7);
         else                    rdy = 1'($urandom_range(0, 1));
         round_ready = rdy;
         @(negedge clk);
         cyc++;
         if (rdy) r++;
      end
      checks++;
      if (r <= 16) begin
         failures++;
         $display("FAIL stall_timeout got round=%0d exp round=17 within 400 cycles", r);
      end
      checks++;
      if (done !== 1'b1 || state_out !== CD0) begin
         failures++;
         $display("FAIL stall_finish got done=%b state=%h exp done=1 state=%h", done, state_out, CD0);
      end
      round_ready = 1'b1;
      @(negedge clk);
      $display("test_stall: done after %0d cycles", cyc);
   endtask

   task automatic test_start_rules;
      int  cyc;
      logic seen_done;
      round_ready = 1'b1;
      launch(KEY, 1'b0);
      for (int r = 1; r <= 16; r++) begin
         checks++;
         if (state_out !== ENC[r-1]) begin
            failures++;
            $display("FAIL busy_start_state r=%0d got=%h exp=%h", r, state_out, ENC[r-1]);
         end
         start   = (r == 5);
         decrypt = 1'b1;
         key_in  = ~KEY;
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL busy_start_done got done=%b exp 1", done);
      end
      // Start coincident with done: must be taken immediately.
      key_in  = KEY;
      decrypt = 1'b1;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      checks++;
      if (round_valid !== 1'b1 || round_idx !== 4'h1 || state_out !== ENC[15]) begin
         failures++;
         $display("FAIL b2b_start got v=%b idx=%h state=%h exp v=1 idx=1 state=%h", round_valid, round_idx, state_out, ENC[15]);
      end
      seen_done = 1'b0;
      cyc = 0;
      while (!seen_done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         seen_done = done;
      end
      checks++;
      if (!seen_done || cyc != 16 || state_out !== CD0) begin
         failures++;
         $display("FAIL b2b_finish got seen_done=%b cyc=%0d state=%h exp 1 cyc=16 state=%h", seen_done, cyc, state_out, CD0);
      end
      @(negedge clk);
      $display("test_start_rules: done");
   endtask

   task automatic test_reset_mid;
      logic seen_done;
      round_ready = 1'b1;
      launch(KEY, 1'b0);
      repeat (8) @(negedge clk);
      checks++;
      if (round_idx !== 4'h9 || state_out !== ENC[8]) begin
         failures++;
         $display("FAIL mid_pre_reset got idx=%h state=%h exp idx=9 state=%h", round_idx, state_out, ENC[8]);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (state_out !== 56'h0 || round_idx !== 4'h0 || {round_valid, busy, done, last_round} !== 4'b0000) begin
         failures++;
         $display("FAIL mid_async_reset got state=%h idx=%h v/b/d/l=%b exp all zero", state_out, round_idx, {round_valid, busy, done, last_round});
      end
      @(negedge clk);
      rst = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
      end
      checks++;
      if (seen_done) begin
         failures++;
         $display("FAIL mid_no_done got done/busy activity=1 exp 0");
      end
      launch(KEY, 1'b0);
      checks++;
      if (round_idx !== 4'h1 || state_out !== ENC[0]) begin
         failures++;
         $display("FAIL mid_restart got idx=%h state=%h exp idx=1 state=%h", round_idx, state_out, ENC[0]);
      end
      repeat (17) @(negedge clk);
      $display("test_reset_mid: done");
   endtask

   initial begin
      test_reset();
      test_encrypt();
      test_decrypt();
      test_stall();
      test_start_rules();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
